// File: rtl/mole_pkg.sv
// Shared types, default timing constants and arithmetic helpers for the mole pad responder.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PULSE        = 2'd1,
    RELEASE_WAIT = 2'd2
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES  = 1000000;
  localparam int unsigned HIT_PULSE_CYCLES = 1000;

  // Adds b to a, clamping at max_val; a is assumed already <= max_val.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_val);
    int unsigned room;
    room = max_val - a;
    return (b > room) ? max_val : a + b;
  endfunction

endpackage

// File: rtl/mole_debounce.sv
// One button channel: 2-flop synchronizer, stable-level debounce counter and press strobe.
module mole_debounce
  import mole_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = mole_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          btn_m;
  logic          btn_s;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles in which the synchronized level disagrees with stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      btn_m <= btn_raw;
      btn_s <= btn_m;
      press <= 1'b0;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= ~stable;
        press  <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mole_pad_responder.sv
// Player-side pad responder: debounced buttons, per-channel hit/miss FSMs, lamp drive and tallies.
// state        | meaning
// IDLE         | waiting for a debounced press
// PULSE        | accepted hit, hit_n held low for HIT_PULSE_CYCLES
// RELEASE_WAIT | event already reported, waiting for the button to be released
module mole_pad_responder
  import mole_pkg::*;
#(
  parameter int          NUM_CH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = mole_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned HIT_PULSE_CYCLES = mole_pkg::HIT_PULSE_CYCLES,
  parameter int          CNT_W            = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] target_up,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] hit_n,
  output logic [NUM_CH-1:0] lamp,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int          PW      = $clog2(HIT_PULSE_CYCLES) + 1;
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [NUM_CH-1:0] tu_m;
  logic [NUM_CH-1:0] tu_s;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] hit_ev;
  logic [NUM_CH-1:0] miss_ev;
  int unsigned       n_hit;
  int unsigned       n_miss;

  state_t            state [NUM_CH];
  logic [PW-1:0]     pcnt  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
    mole_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[g]),
      .stable (stable[g]),
      .press  (press[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tu_m <= '0;
      tu_s <= '0;
      lamp <= '0;
    end else begin
      tu_m <= target_up;
      tu_s <= tu_m;
      lamp <= tu_s;
    end
  end

  // tu_s matters only in the press cycle; later target changes cannot alter the outcome.
  always_comb begin
    hit_ev  = '0;
    miss_ev = '0;
    n_hit   = 0;
    n_miss  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_ev[i]  = (state[i] == IDLE) & press[i] & tu_s[i];
      miss_ev[i] = (state[i] == IDLE) & press[i] & ~tu_s[i];
      n_hit      = n_hit + 32'(hit_ev[i]);
      n_miss     = n_miss + 32'(miss_ev[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_n <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        pcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (hit_ev[i]) begin
              state[i] <= PULSE;
              hit_n[i] <= 1'b0;
              pcnt[i]  <= PW'(HIT_PULSE_CYCLES - 1);
            end else if (miss_ev[i]) begin
              state[i] <= RELEASE_WAIT;
            end
          end
          PULSE: begin
            if (pcnt[i] == '0) begin
              state[i] <= RELEASE_WAIT;
              hit_n[i] <= 1'b1;
            end else begin
              pcnt[i] <= pcnt[i] - 1'b1;
            end
          end
          RELEASE_WAIT: begin
            if (!stable[i]) state[i] <= IDLE;
          end
          default: begin
            state[i] <= IDLE;
            hit_n[i] <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= CNT_W'(sat_add(32'(hit_count), n_hit, CNT_MAX));
      miss_count <= CNT_W'(sat_add(32'(miss_count), n_miss, CNT_MAX));
    end
  end

endmodule
